regfile_dump_ctrl: RTL and testbench

//  Debug sequencer that owns the register file's second read port while the CPU is halted.
//  On a start pulse it walks addresses 0..NUM_REGISTERS-1 and captures each word.

---
 rtl/regfile_dump_ctrl.sv | 96 +++++++++
 tb/tb_regfile_dump_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump_ctrl.sv
// rtl/regfile_dump_ctrl.sv - register file dump sequencer
// Walks the regfile read port while halted and streams each word MSB-byte-first to a byte sink.
module regfile_dump_ctrl #(
  parameter int WIDTH         = 32,
  parameter int WIDTH_ADD     = 5,
  parameter int NUM_REGISTERS = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic [WIDTH_ADD-1:0] rf_rd_addr,
  input  logic [WIDTH-1:0]     rf_rd_data,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic                 hold,
  output logic                 busy,
  output logic                 done
);

  localparam int BYTES = WIDTH / 8;
  localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [CNT_W-1:0]     LAST_BYTE = CNT_W'(BYTES - 1);
  localparam logic [WIDTH_ADD-1:0] LAST_ADDR = WIDTH_ADD'(NUM_REGISTERS - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND,
    DONE
  } state_t;

  state_t            state;
  logic [WIDTH-1:0]  shift_reg;
  logic [WIDTH-1:0]  shifted;
  logic [CNT_W-1:0]  byte_cnt;
  logic              xfer;

  assign shifted = shift_reg << 8;
  assign xfer    = tx_valid & tx_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      tx_valid   <= 1'b0;
      tx_data    <= 8'h00;
      rf_rd_addr <= '0;
      byte_cnt   <= '0;
      shift_reg  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            rf_rd_addr <= '0;
            state      <= LOAD;
          end
        end
        LOAD: begin
          shift_reg <= rf_rd_data;
          byte_cnt  <= '0;
          tx_valid  <= 1'b1;
          tx_data   <= rf_rd_data[WIDTH-1 -: 8];
          state     <= SEND;
        end
        SEND: begin
          // Next byte follows immediately on acceptance so the stream has no bubbles within a word.
          if (xfer) begin
            if (byte_cnt != LAST_BYTE) begin
              shift_reg <= shifted;
              tx_data   <= shifted[WIDTH-1 -: 8];
              byte_cnt  <= byte_cnt + CNT_W'(1);
            end else begin
              tx_valid <= 1'b0;
              if (rf_rd_addr != LAST_ADDR) begin
                rf_rd_addr <= rf_rd_addr + WIDTH_ADD'(1);
                state      <= LOAD;
              end else begin
                state <= DONE;
              end
            end
          end
        end
        DONE: begin
          rf_rd_addr <= '0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == LOAD) || (state == SEND);
  assign hold = busy;
  assign done = (state == DONE);

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// tb/tb_regfile_dump_ctrl.sv - scoreboard bench for regfile_dump_ctrl
module tb_regfile_dump_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, tx_ready;
  logic [4:0]  rf_rd_addr;
  logic [31:0] rf_rd_data;
  logic [7:0]  tx_data;
  logic        tx_valid, hold, busy, done;
  logic [31:0] regs [32];
  assign rf_rd_data = regs[rf_rd_addr];

  logic        start8, ready8;
  logic [1:0]  addr8;
  logic [7:0]  data8, tx_data8;
  logic        tx_valid8, hold8, busy8, done8;
  logic [7:0]  regs8 [4];
  assign data8 = regs8[addr8];

  regfile_dump_ctrl dut (
    .clk(clk), .reset(reset), .start(start),
    .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .hold(hold), .busy(busy), .done(done)
  );

  regfile_dump_ctrl #(.WIDTH(8), .WIDTH_ADD(2), .NUM_REGISTERS(4)) dut8 (
    .clk(clk), .reset(reset), .start(start8),
    .rf_rd_addr(addr8), .rf_rd_data(data8),
    .tx_data(tx_data8), .tx_valid(tx_valid8), .tx_ready(ready8),
    .hold(hold8), .busy(busy8), .done(done8)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] exp_q [$];
  logic [7:0] exp_byte;
  int  pending_done = 0;
  int  start_cyc = 0;
  bit  timing_chk = 0;
  int  rx_count = 0;
  int  mode = 0;
  int  stall_left = 0;
  bit  stalling = 0;
  bit  prev_stall = 0;
  logic [7:0] prev_data = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Sink model: 0 always ready, 1 toggling, 2 random, 3 a 20-cycle stall on reg 7 byte 3
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      stalling = 1'b0;
      case (mode)
        0: tx_ready = 1'b1;
        1: tx_ready = ~tx_ready;
        2: tx_ready = 1'($urandom_range(0, 1));
        default: begin
          if (rx_count == 31 && tx_valid && stall_left > 0) begin
            tx_ready = 1'b0;
            stall_left--;
            stalling = 1'b1;
          end else begin
            tx_ready = 1'b1;
          end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      check("hold_eq_busy", 32'(hold), 32'(busy));
      if (prev_stall) begin
        check("held_valid", 32'(tx_valid), 32'd1);
        check("held_data", 32'(tx_data), 32'(prev_data));
      end
      if (stalling) begin
        check("stall_addr", 32'(rf_rd_addr), 32'd7);
        check("stall_hold", 32'(hold), 32'd1);
      end
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_byte: got %0h expected none", tx_data);
        end else begin
          exp_byte = exp_q.pop_front();
          check("byte", 32'(tx_data), 32'(exp_byte));
        end
        rx_count++;
      end
      if (done) begin
        if (pending_done == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got 1 expected 0 at cycle %0d", cyc);
        end else begin
          pending_done--;
          check("done_bytes_left", 32'(exp_q.size()), 32'd0);
          if (timing_chk) check("done_latency", 32'(cyc - start_cyc), 32'd161);
        end
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic start_dump(input bit timed);
    @(posedge clk);
    #1;
    for (int r = 0; r < 32; r++)
      for (int b = 3; b >= 0; b--)
        exp_q.push_back(8'(regs[r] >> (8 * b)));
    pending_done++;
    timing_chk = timed;
    start_cyc  = cyc;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check("load_busy", 32'(busy), 32'd1);
    check("load_valid", 32'(tx_valid), 32'd0);
    @(negedge clk);
    check("first_valid", 32'(tx_valid), 32'd1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done expected done within 2000 cycles");
    end
    @(posedge clk);
    #1;
    check("pending_done", 32'(pending_done), 32'd0);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    int got8;
    int done8_seen;
    reset  = 1'b1;
    start  = 1'b0;
    start8 = 1'b0;
    ready8 = 1'b1;
    fill_random();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 32'(tx_valid), 32'd0);
    check("rst_data", 32'(tx_data), 32'd0);
    check("rst_addr", 32'(rf_rd_addr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_hold", 32'(hold), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Fixed pattern, sink always ready
    for (int i = 0; i < 32; i++) regs[i] = 32'hA0B0C000 + 32'(i);
    mode = 0;
    start_dump(1);
    wait_done();

    // Toggling ready
    fill_random();
    mode = 1;
    start_dump(0);
    wait_done();

    // Long stall on reg 7 byte 3
    fill_random();
    mode = 3;
    stall_left = 20;
    rx_count = 0;
    start_dump(0);
    wait_done();
    check("stall_consumed", 32'(stall_left), 32'd0);

    // Start pulse during the dump is ignored
    fill_random();
    mode = 2;
    start_dump(0);
    n = 0;
    while (rf_rd_addr != 5'd10 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("reached_reg10", 32'(rf_rd_addr), 32'd10);
    @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done();
    repeat (10) @(negedge clk);
    check("idle_after_ignored_start", 32'(busy), 32'd0);
    check("no_extra_bytes", 32'(exp_q.size()), 32'd0);

    // Reset during reg 15
    fill_random();
    mode = 2;
    start_dump(0);
    n = 0;
    while (!(rf_rd_addr == 5'd15 && tx_valid) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("reached_reg15", 32'(rf_rd_addr), 32'd15);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    pending_done = 0;
    @(negedge clk);
    check("abort_valid", 32'(tx_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_addr", 32'(rf_rd_addr), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    repeat (5) @(negedge clk);
    fill_random();
    mode = 0;
    start_dump(1);
    wait_done();

    // Byte-wide, four-register instance
    regs8[0] = 8'h11;
    regs8[1] = 8'h22;
    regs8[2] = 8'h33;
    regs8[3] = 8'h44;
    got8 = 0;
    done8_seen = 0;
    @(posedge clk);
    #1;
    start_cyc = cyc;
    start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (tx_valid8) begin
        if (got8 < 4) check("byte8", 32'(tx_data8), 32'(regs8[got8]));
        got8++;
      end
      if (done8) begin
        done8_seen++;
        check("done8_latency", 32'(cyc - start_cyc), 32'd9);
      end
    end
    check("bytes8_count", 32'(got8), 32'd4);
    check("done8_count", 32'(done8_seen), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
